wdt_supervisor: RTL
===================

# wdt_supervisor

Control FSM that sequences the watchdog datapath: holds a software-loaded timeout/grace configuration, arms and disarms the timer, and counts kicks. On expiry it escalates through interrupt, grace period and system-reset request. It sits between the bus-facing control logic and the chip reset controller and supersedes direct use of the bare watchdog counter.

## Interface
- `CNT_W`, 16: timeout counter width.
- `GRACE_W`, 8: grace counter width.
- `TIMEOUT_DEF`, 10: `timeout_r` reset value.
- `GRACE_DEF`, 4: `grace_r` reset value.
- `RST_PULSE`, 4: `sys_rst_req` pulse length in cycles, ≥1.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: design enable. Low freezes all counters; FSM transitions on `arm`/`disarm`/`cfg_we` still occur.
- `arm` in 1: start watchdog (IDLE only).
- `disarm` in 1: stop watchdog (ARMED only).
- `kick` in 1: service pulse, one per cycle high.
- `irq_ack` in 1: software acknowledge of expiry.
- `cfg_we` in 1: configuration write strobe.
- `cfg_timeout` in CNT_W: timeout in cycles.
- `cfg_grace` in GRACE_W: grace period in cycles.
- `cfg_window` in CNT_W: earliest legal kick count (WDT_WINDOW_EN only, else ignored).
- `irq_warn` out 1: level, count in last quarter of timeout.
- `irq_expired` out 1: level, sticky until ack/reset.
- `sys_rst_req` out 1: reset request pulse.
- `cfg_err` out 1: 1-cycle pulse, rejected config write.
- `state_o` out 3: current FSM state encoding.
- `cause_o` out 2: last escalation cause (0 none, 1 timeout, 2 early kick).

## Operation
- States: IDLE, ARMED, GRACE, RESET.
- IDLE:
  - `arm` → ARMED, `cnt`=0, `cause_o`=0.
  - `cfg_we` loads `timeout_r`/`grace_r`/`window_r`. `cfg_timeout`=0 is stored as 1; `cfg_grace`=0 is legal.
- ARMED:
  - With `ena`, `cnt`++ each cycle.
  - `kick` → `cnt`=0.
  - `cnt`==`timeout_r`-1 and no kick, with `ena` → GRACE: `irq_expired`=1, `cause_o`=1, `gcnt`=0.
  - `disarm` → IDLE, `cnt`=0.
- GRACE:
  - With `ena`, `gcnt`++; `kick` ignored.
  - `irq_ack` → ARMED, `cnt`=0, `irq_expired`=0.
  - `gcnt`==`grace_r` with no ack → RESET. With `grace_r`=0, RESET is entered on the next edge.
- RESET:
  - `sys_rst_req`=1 for exactly RST_PULSE cycles, counted regardless of `ena`; then → IDLE.
  - `irq_expired` and `cause_o` are retained in IDLE until the next `arm`.
- `irq_warn` = (state==ARMED) && `cnt` ≥ `timeout_r` − (`timeout_r`>>2). Registered, so it is valid the cycle after `cnt` changes.
- `cfg_we` outside IDLE: config unchanged, `cfg_err` pulses 1 cycle.
- `arm` outside IDLE, `disarm` outside ARMED, and `irq_ack` outside GRACE are ignored.
- Priority for simultaneous events in ARMED: `disarm` > `kick` > expiry. A kick on the expiry cycle prevents expiry.
- Priority in GRACE: `irq_ack` > grace expiry.
- Arithmetic is unsigned, and counters never wrap: `cnt` is bounded by `timeout_r`-1 and `gcnt` by `grace_r`.
- `rst_n` low at any time, including mid-pulse: all outputs 0, state IDLE, `timeout_r`=TIMEOUT_DEF, `grace_r`=GRACE_DEF, `window_r`=0.

## Timing
- All outputs are registered. Reset values are all 0, and `state_o` = IDLE (0).
- `arm` sampled at edge N: `state_o`=ARMED after N.
- No kicks, `ena` held high: `irq_expired` rises `timeout_r` cycles after ARMED entry.
- `sys_rst_req` rises `grace_r`+1 cycles after `irq_expired` rises, and stays high RST_PULSE cycles.
- `cfg_err` is high the cycle after the offending `cfg_we`.
- Kick latency: `cnt` reads 0 the cycle after `kick`.

## Configuration
- `WDT_WINDOW_EN` defined (windowed watchdog):
  - `kick` in ARMED with `cnt` < `window_r` is an early-kick fault → GRACE with `cause_o`=2 and `irq_expired`=1.
  - `window_r` ≥ `timeout_r` is clamped to `timeout_r`-1 on load.
- Not defined: `cfg_window` and `window_r` are absent in logic, every kick is legal, and `cause_o` is never 2.

## Structure
- Package `wdt_pkg` holds:
  - the state enum (IDLE=0, ARMED=1, GRACE=2, RESET=3);
  - the cause encoding (CAUSE_NONE/TIMEOUT/EARLY);
  - the default width constants.
- One sub-module, `wdt_counter`: loadable up-counter with clear, enable and terminal-compare output. It is instantiated for `cnt`; `gcnt` and the pulse counter are inline.

## Test plan
- Defaults, arm, no kicks: `irq_expired`=1 and `cause_o`=1 exactly 10 cycles after ARMED entry. `sys_rst_req` high 4 cycles starting 5 cycles later, then `state_o`=IDLE.
- Arm, kick every 8 cycles for 100 cycles: `irq_expired` stays 0. `irq_warn` pulses while `cnt` is 8..9; with kicks every 8 cycles, `cnt` reaches 7 max, so `irq_warn` never rises.
- Expiry, then `irq_ack` 2 cycles into GRACE: back to ARMED, `irq_expired`=0, `sys_rst_req` never asserted.
- `cfg_we` while ARMED with timeout=50: `cfg_err` pulses once, and expiry still occurs at 10 cycles.
- Kick and disarm in the same cycle, then kick on the exact expiry cycle: disarm wins, giving IDLE. After re-arm, the expiry-cycle kick prevents GRACE.
- `rst_n` low mid-RESET pulse: `sys_rst_req` drops immediately and all outputs read 0. With `WDT_WINDOW_EN` and window=5, a kick at `cnt`=2 → GRACE with `cause_o`=2.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog supervisor.
//   wdt_state_e : supervisor FSM state (value is exported on state_o)
//   wdt_cause_e : last escalation cause (value is exported on cause_o)
//   CNT_W_DEF / GRACE_W_DEF : default counter widths
package wdt_pkg;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned GRACE_W_DEF = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StGrace = 3'd2,
    StReset = 3'd3
  } wdt_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_TIMEOUT = 2'd1,
    CAUSE_EARLY   = 2'd2
  } wdt_cause_e;

endpackage

// File: rtl/wdt_counter.sv
// Loadable up-counter with synchronous clear, count enable and terminal compare.
// The counter saturates at the terminal value, so it never wraps.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force count to zero (highest priority)
//   load       : load load_val (below clr)
//   en         : increment while below term
//   term       : terminal value; at_term is high while count == term
//   count      : current count
module wdt_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  logic [W-1:0] count_q, count_d;

  assign at_term = (count_q == term);
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && !at_term) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wdt_supervisor.sv
// Watchdog supervisor: holds timeout/grace configuration, arms/disarms the timeout
// counter, and escalates an expiry through interrupt, grace period and a
// fixed-length system reset request.
// Optional feature: define WDT_WINDOW_EN for a windowed watchdog (early kicks fault).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   ena                   : count enable (FSM still reacts to arm/disarm/cfg_we)
//   arm, disarm, kick     : control pulses
//   irq_ack               : acknowledge of expiry while in grace
//   cfg_we, cfg_timeout,
//   cfg_grace, cfg_window : configuration write (accepted only in idle)
//   irq_warn              : count is in the last quarter of the timeout (registered)
//   irq_expired           : sticky expiry flag
//   sys_rst_req           : RST_PULSE-cycle reset request
//   cfg_err               : one-cycle pulse for a rejected configuration write
//   state_o, cause_o      : current state, last escalation cause
module wdt_supervisor
  import wdt_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned GRACE_W     = GRACE_W_DEF,
  parameter int unsigned TIMEOUT_DEF = 10,
  parameter int unsigned GRACE_DEF   = 4,
  parameter int unsigned RST_PULSE   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               arm,
  input  logic               disarm,
  input  logic               kick,
  input  logic               irq_ack,
  input  logic               cfg_we,
  input  logic [CNT_W-1:0]   cfg_timeout,
  input  logic [GRACE_W-1:0] cfg_grace,
  input  logic [CNT_W-1:0]   cfg_window,
  output logic               irq_warn,
  output logic               irq_expired,
  output logic               sys_rst_req,
  output logic               cfg_err,
  output logic [2:0]         state_o,
  output logic [1:0]         cause_o
);

  localparam int unsigned PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  wdt_state_e         state_q, state_d;
  wdt_cause_e         cause_q, cause_d;
  logic               irq_exp_q, irq_exp_d;
  logic               rst_req_q, rst_req_d;
  logic               cfg_err_q, cfg_err_d;
  logic               warn_q, warn_d;
  logic [CNT_W-1:0]   timeout_q, timeout_d;
  logic [GRACE_W-1:0] grace_q, grace_d;
  logic [GRACE_W-1:0] gcnt_q, gcnt_d;
  logic [PW-1:0]      pcnt_q, pcnt_d;

  logic [CNT_W-1:0]   cnt;
  logic               cnt_term;
  logic               cnt_clr;
  logic [CNT_W-1:0]   timeout_eff;
  logic [CNT_W-1:0]   warn_thr;
  logic               early_kick;

  // A zero timeout would make the terminal value underflow; store it as 1.
  assign timeout_eff = (cfg_timeout == '0) ? CNT_W'(1) : cfg_timeout;
  assign warn_thr    = timeout_q - (timeout_q >> 2);

`ifdef WDT_WINDOW_EN
  logic [CNT_W-1:0] window_q, window_d, window_clamped;

  // Keep at least one legal kick count below the terminal value.
  assign window_clamped = (cfg_window >= timeout_eff) ? timeout_eff - CNT_W'(1) : cfg_window;
  assign early_kick     = (cnt < window_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q <= '0;
    end else begin
      window_q <= window_d;
    end
  end
`else
  logic unused_window;

  assign unused_window = ^cfg_window;
  assign early_kick    = 1'b0;
`endif

  wdt_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (ena && (state_q == StArmed)),
    .load     (1'b0),
    .load_val ('0),
    .term     (timeout_q - CNT_W'(1)),
    .count    (cnt),
    .at_term  (cnt_term)
  );

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    irq_exp_d = irq_exp_q;
    rst_req_d = 1'b0;
    timeout_d = timeout_q;
    grace_d   = grace_q;
    gcnt_d    = gcnt_q;
    pcnt_d    = pcnt_q;
    cnt_clr   = 1'b0;
`ifdef WDT_WINDOW_EN
    window_d  = window_q;
`endif
    cfg_err_d = cfg_we && (state_q != StIdle);
    warn_d    = (state_q == StArmed) && (cnt >= warn_thr);

    unique case (state_q)
      StIdle: begin
        if (cfg_we) begin
          timeout_d = timeout_eff;
          grace_d   = cfg_grace;
`ifdef WDT_WINDOW_EN
          window_d  = window_clamped;
`endif
        end
        if (arm) begin
          state_d   = StArmed;
          cnt_clr   = 1'b1;
          cause_d   = CAUSE_NONE;
          irq_exp_d = 1'b0;
        end
      end
      StArmed: begin
        if (disarm) begin
          state_d = StIdle;
          cnt_clr = 1'b1;
        end else if (kick) begin
          cnt_clr = 1'b1;
          if (early_kick) begin
            state_d   = StGrace;
            irq_exp_d = 1'b1;
            cause_d   = CAUSE_EARLY;
            gcnt_d    = '0;
          end
        end else if (ena && cnt_term) begin
          state_d   = StGrace;
          cnt_clr   = 1'b1;
          irq_exp_d = 1'b1;
          cause_d   = CAUSE_TIMEOUT;
          gcnt_d    = '0;
        end
      end
      StGrace: begin
        if (irq_ack) begin
          state_d   = StArmed;
          cnt_clr   = 1'b1;
          irq_exp_d = 1'b0;
        end else if (gcnt_q == grace_q) begin
          state_d   = StReset;
          rst_req_d = 1'b1;
          pcnt_d    = '0;
        end else if (ena) begin
          gcnt_d = gcnt_q + GRACE_W'(1);
        end
      end
      StReset: begin
        // Pulse length is fixed; it does not stall on ena.
        if (pcnt_q == PW'(RST_PULSE - 1)) begin
          state_d = StIdle;
        end else begin
          pcnt_d    = pcnt_q + PW'(1);
          rst_req_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cause_q   <= CAUSE_NONE;
      irq_exp_q <= 1'b0;
      rst_req_q <= 1'b0;
      cfg_err_q <= 1'b0;
      warn_q    <= 1'b0;
      timeout_q <= CNT_W'(TIMEOUT_DEF);
      grace_q   <= GRACE_W'(GRACE_DEF);
      gcnt_q    <= '0;
      pcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      irq_exp_q <= irq_exp_d;
      rst_req_q <= rst_req_d;
      cfg_err_q <= cfg_err_d;
      warn_q    <= warn_d;
      timeout_q <= timeout_d;
      grace_q   <= grace_d;
      gcnt_q    <= gcnt_d;
      pcnt_q    <= pcnt_d;
    end
  end

  assign state_o     = state_q;
  assign cause_o     = cause_q;
  assign irq_expired = irq_exp_q;
  assign sys_rst_req = rst_req_q;
  assign cfg_err     = cfg_err_q;
  assign irq_warn    = warn_q;

endmodule
